// File: rtl/ttl_seq_pkg.sv
// Shared state encoding for the nibble-serial adder sequencers.
package ttl_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ttl_nibble_shifter.sv
// Parallel-load register that shifts right by one nibble per clock,
// taking a new nibble in at the top.
module ttl_nibble_shifter
    import ttl_seq_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NIBBLE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    shift,
    input  logic [WIDTH-1:0]        load_data,
    input  logic [NIBBLE_WIDTH-1:0] nibble_in,
    output logic [WIDTH-1:0]        q
);

    logic [WIDTH-1:0] shifted;

    // A single-nibble register is simply replaced on each shift.
    if (WIDTH == NIBBLE_WIDTH) begin : g_single
        assign shifted = nibble_in;
    end else begin : g_multi
        assign shifted = {nibble_in, q[WIDTH-1:NIBBLE_WIDTH]};
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order in which the simulator runs the blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/ttl_adder_sequencer.sv
// Time-shares one external 4-bit adder slice to add or subtract full-width
// operands nibble by nibble, LSB first, with a Start/Busy/Done handshake.
module ttl_adder_sequencer
    import ttl_seq_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16,
    parameter int NIBBLE_WIDTH  = 4
) (
    input  logic                     Clk,
    input  logic                     Clear_bar,
    input  logic                     Start,
    input  logic                     Sub,
    input  logic [OPERAND_WIDTH-1:0] A_in,
    input  logic [OPERAND_WIDTH-1:0] B_in,
    output logic                     Busy,
    output logic                     Done,
    output logic [OPERAND_WIDTH-1:0] Result,
    output logic                     C_out,
    output logic                     Overflow,
    output logic [NIBBLE_WIDTH-1:0]  Adder_A,
    output logic [NIBBLE_WIDTH-1:0]  Adder_B,
    output logic                     Adder_Cin,
    input  logic [NIBBLE_WIDTH-1:0]  Adder_Sum,
    input  logic                     Adder_Cout
);

    localparam int OW      = OPERAND_WIDTH;
    localparam int NW      = NIBBLE_WIDTH;
    localparam int NIBBLES = OW / NW;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    seq_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             running, accept, final_pass;
    logic [OW-1:0]    a_sh, b_sh, acc_sh;
    logic [OW-1:0]    result_next;
    logic             unused_bits;

    assign running    = (state == SEQ_RUN);
    assign accept     = Start && !running;
    assign final_pass = running && (cnt == LAST_CNT);
    assign Busy       = running;
    assign Done       = (state == SEQ_DONE);

    ttl_nibble_shifter #(.WIDTH(OW), .NIBBLE_WIDTH(NW)) u_a_sh (
        .clk(Clk), .rst_n(Clear_bar), .load(accept), .shift(running),
        .load_data(A_in), .nibble_in('0), .q(a_sh)
    );

    ttl_nibble_shifter #(.WIDTH(OW), .NIBBLE_WIDTH(NW)) u_b_sh (
        .clk(Clk), .rst_n(Clear_bar), .load(accept), .shift(running),
        .load_data(Sub ? ~B_in : B_in), .nibble_in('0), .q(b_sh)
    );

    ttl_nibble_shifter #(.WIDTH(OW), .NIBBLE_WIDTH(NW)) u_acc_sh (
        .clk(Clk), .rst_n(Clear_bar), .load(1'b0), .shift(running),
        .load_data('0), .nibble_in(Adder_Sum), .q(acc_sh)
    );

    // Nibbles already consumed by the adder are never read back.
    if (NIBBLES == 1) begin : g_single
        assign result_next = Adder_Sum;
        assign unused_bits = ^acc_sh;
    end else begin : g_multi
        assign result_next = {Adder_Sum, acc_sh[OW-1:NW]};
        assign unused_bits = ^{a_sh[OW-1:NW], b_sh[OW-1:NW], acc_sh[NW-1:0]};
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) state <= SEQ_IDLE;
        else            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            SEQ_IDLE: if (Start) state_next = SEQ_RUN;
            SEQ_RUN:  if (cnt == LAST_CNT) state_next = SEQ_DONE;
            SEQ_DONE: state_next = Start ? SEQ_RUN : SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    always_comb begin
        Adder_A   = '0;
        Adder_B   = '0;
        Adder_Cin = 1'b0;
        if (running) begin
            Adder_A   = a_sh[NW-1:0];
            Adder_B   = b_sh[NW-1:0];
            Adder_Cin = carry;
        end
    end

    // The carry flop seeds with Sub so subtraction becomes A + ~B + 1.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            carry <= Sub;
            cnt   <= '0;
        end else if (running) begin
            carry <= Adder_Cout;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            Result   <= '0;
            C_out    <= 1'b0;
            Overflow <= 1'b0;
        end else if (final_pass) begin
            Result   <= result_next;
            C_out    <= Adder_Cout;
            Overflow <= (Adder_A[NW-1] == Adder_B[NW-1]) &&
                        (Adder_Sum[NW-1] != Adder_A[NW-1]);
        end
    end

endmodule

// File: tb/tb_ttl_adder_sequencer.sv
// Directed bench for ttl_adder_sequencer with a behavioural 74283 slice
// closing the loop on the Adder_* ports.
module tb_ttl_adder_sequencer;

    localparam int OW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, sub;
    logic [OW-1:0] a_in, b_in, result;
    logic          busy, done, c_out, overflow;
    logic [NW-1:0] adder_a, adder_b, adder_sum;
    logic          adder_cin, adder_cout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ttl_74283 equivalent: 4-bit binary full adder with carry in/out.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{NW{1'b0}}, adder_cin};

    ttl_adder_sequencer #(.OPERAND_WIDTH(OW), .NIBBLE_WIDTH(NW)) dut (
        .Clk(clk), .Clear_bar(rst_n), .Start(start), .Sub(sub),
        .A_in(a_in), .B_in(b_in), .Busy(busy), .Done(done),
        .Result(result), .C_out(c_out), .Overflow(overflow),
        .Adder_A(adder_a), .Adder_B(adder_b), .Adder_Cin(adder_cin),
        .Adder_Sum(adder_sum), .Adder_Cout(adder_cout)
    );

    // Waits (bounded) for Done; cycle 1 is the cycle right after the start edge.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 1;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cycles);
        end
    endtask

    // Issues one operation, scrambles the inputs after acceptance, returns in the Done cycle.
    task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic s,
                          output int cycles, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sub = s;
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b; sub = ~s;
        wait_done(cycles, busy_cycles);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, c_out, overflow, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b c_out=%b ovf=%b result=%h, required all 0",
                     busy, done, c_out, overflow, result);
        end
        n_checks++;
        if ({adder_a, adder_b, adder_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_adder_drive: a=%h b=%h cin=%b, required 0", adder_a, adder_b, adder_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [OW-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [OW-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0001};
        logic [OW-1:0] vr [3] = '{16'h5555, 16'h0000, 16'h8000};
        logic          vc [3] = '{1'b0, 1'b1, 1'b0};
        logic          vv [3] = '{1'b0, 1'b0, 1'b1};
        int cycles, busy_cycles;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, cycles, busy_cycles);
            n_checks++;
            if ({result, c_out, overflow} !== {vr[i], vc[i], vv[i]}) begin
                n_fail++;
                $display("FAIL add_%0d: result=%h c_out=%b ovf=%b, required %h %b %b",
                         i, result, c_out, overflow, vr[i], vc[i], vv[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (cycles !== 5 || busy_cycles !== 4 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL add_latency: done_cycle=%0d busy_cycles=%0d busy_at_done=%b, required 5 4 0",
                             cycles, busy_cycles, busy);
                end
                @(negedge clk);
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_one_cycle: done=%b, required 0", done);
                end
            end
        end
    endtask

    task automatic test_sub();
        int cycles, busy_cycles;
        run_op(16'h0005, 16'h0007, 1'b1, cycles, busy_cycles);
        n_checks++;
        if ({result, c_out, overflow} !== {16'hFFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_5_7: result=%h c_out=%b ovf=%b, required fffe 0 0", result, c_out, overflow);
        end
        run_op(16'h8000, 16'h0001, 1'b1, cycles, busy_cycles);
        n_checks++;
        if ({result, c_out, overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_8000_1: result=%h c_out=%b ovf=%b, required 7fff 1 1", result, c_out, overflow);
        end
    endtask

    task automatic test_ignore_start();
        int cycles, busy_cycles;
        @(negedge clk);
        start = 1'b1; a_in = 16'h1234; b_in = 16'h4321; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 3;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles !== 5 || {result, c_out, overflow} !== {16'h5555, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_start: done_cycle=%0d result=%h c_out=%b ovf=%b, required 5 5555 0 0",
                     cycles, result, c_out, overflow);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int cycles, busy_cycles;
        run_op(16'h0003, 16'h0004, 1'b0, cycles, busy_cycles);
        n_checks++;
        if (result !== 16'h0007) begin
            n_fail++;
            $display("FAIL b2b_first: result=%h, required 0007", result);
        end
        start = 1'b1; a_in = 16'h00F0; b_in = 16'h0010; sub = 1'b0;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        n_checks++;
        if ({busy, done, result} !== {1'b1, 1'b0, 16'h0007}) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b result=%h, required 1 0 0007", busy, done, result);
        end
        wait_done(cycles, busy_cycles);
        n_checks++;
        if (cycles !== 5 || result !== 16'h0100) begin
            n_fail++;
            $display("FAIL b2b_second: done_cycle=%0d result=%h, required 5 0100", cycles, result);
        end
    endtask

    task automatic test_abort();
        int cycles, busy_cycles;
        run_op(16'h8000, 16'h0001, 1'b1, cycles, busy_cycles);
        @(negedge clk);
        start = 1'b1; a_in = 16'h1234; b_in = 16'h4321; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, result, c_out, overflow} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_mid_run: busy=%b result=%h c_out=%b ovf=%b, required 1 7fff 1 1",
                     busy, result, c_out, overflow);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, c_out, overflow, result, adder_a, adder_b, adder_cin} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b done=%b c_out=%b ovf=%b result=%h a=%h b=%h cin=%b, required all 0",
                     busy, done, c_out, overflow, result, adder_a, adder_b, adder_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        run_op(16'h0001, 16'h0001, 1'b0, cycles, busy_cycles);
        n_checks++;
        if (cycles !== 5 || {result, c_out, overflow} !== {16'h0002, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_fresh: done_cycle=%0d result=%h c_out=%b ovf=%b, required 5 0002 0 0",
                     cycles, result, c_out, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
